// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through a round-robin arbiter.
// The FSM steps IDLE -> EXEC -> RESP. The result is held in RESP until the
// consumer takes it.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   reqN_valid / reqN_ready   request handshake for requester N (N = 0, 1)
//   reqN_fun                  0 add, 1 sub (b-a), 2 and, 3 xor, >3 invalid
//   reqN_a, reqN_b            signed W-bit operands
//   resp_valid / resp_ready   response handshake
//   resp_id                   requester that owns the result
//   resp_val                  ALU result
//   resp_cc                   condition codes {ZF, SF, OF}
//   resp_err                  set when the function code was invalid
module alu_arbiter #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [3:0]   req0_fun,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [3:0]   req1_fun,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic         resp_id,
   output logic [W-1:0] resp_val,
   output logic [2:0]   resp_cc,
   output logic         resp_err
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t       state_q;
   logic         last_grant_q;
   logic [3:0]   fun_q;
   logic [W-1:0] a_q, b_q;
   logic         id_q;
   logic         resp_valid_q, resp_id_q, resp_err_q;
   logic [W-1:0] resp_val_q;
   logic [2:0]   resp_cc_q;

   logic         grant_id, accept;
   logic [W-1:0] alu_val;
   logic         alu_of, alu_err;
   logic [2:0]   alu_cc;

   // Round-robin: on a tie the requester not served last wins; otherwise
   // whichever is valid (grant_id only matters when accept is high).
   always_comb begin
      if (req0_valid && req1_valid) grant_id = ~last_grant_q;
      else                          grant_id = req1_valid;
      accept     = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
      req0_ready = accept && !grant_id;
      req1_ready = accept &&  grant_id;
   end

   // Shared ALU, fed only from the latched operands.
   always_comb begin
      alu_val = '0;
      alu_of  = 1'b0;
      alu_err = 1'b0;
      case (fun_q)
         4'd0: begin
            alu_val = a_q + b_q;
            alu_of  = (a_q[W-1] == b_q[W-1]) && (alu_val[W-1] != a_q[W-1]);
         end
         4'd1: begin
            alu_val = b_q - a_q;
            alu_of  = (a_q[W-1] != b_q[W-1]) && (alu_val[W-1] != b_q[W-1]);
         end
         4'd2:    alu_val = a_q & b_q;
         4'd3:    alu_val = a_q ^ b_q;
         default: alu_err = 1'b1;
      endcase
      // An invalid op reports all-zero flags, so ZF is masked too.
      alu_cc = alu_err ? 3'b000 : {(alu_val == '0), alu_val[W-1], alu_of};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_val_q   <= '0;
         resp_cc_q    <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  fun_q        <= grant_id ? req1_fun : req0_fun;
                  a_q          <= grant_id ? req1_a   : req0_a;
                  b_q          <= grant_id ? req1_b   : req0_b;
                  id_q         <= grant_id;
                  last_grant_q <= grant_id;
                  state_q      <= EXEC;
               end
            end
            EXEC: begin
               resp_val_q   <= alu_val;
               resp_cc_q    <= alu_cc;
               resp_err_q   <= alu_err;
               resp_id_q    <= id_q;
               resp_valid_q <= 1'b1;
               state_q      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_val   = resp_val_q;
   assign resp_cc    = resp_cc_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed cases followed by randomized
// transactions, checked against a behavioural arithmetic/arbitration model.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]  req0_fun, req1_fun;
   logic [63:0] req0_a, req0_b, req1_a, req1_b;
   logic        resp_valid, resp_ready, resp_id, resp_err;
   logic [63:0] resp_val;
   logic [2:0]  resp_cc;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic        last_m;   // requester served last, per the model

   localparam logic signed [64:0] MAXS = 65'sh0_7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [64:0] MINS = -65'sh0_8000_0000_0000_0000;

   alu_arbiter #(.W(64)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_val(resp_val), .resp_cc(resp_cc), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact signed arithmetic in 65 bits, overflow = out of range.
   task automatic ref_alu(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] v, output logic [2:0] cc, output logic e);
      logic signed [64:0] ea, eb, wide;
      logic ofl;
      ea = $signed({a[63], a});
      eb = $signed({b[63], b});
      ofl = 1'b0;
      e = 1'b0;
      v = '0;
      case (f)
         4'd0: begin wide = ea + eb; v = wide[63:0]; ofl = (wide > MAXS) || (wide < MINS); end
         4'd1: begin wide = eb - ea; v = wide[63:0]; ofl = (wide > MAXS) || (wide < MINS); end
         4'd2: v = a & b;
         4'd3: v = a ^ b;
         default: e = 1'b1;
      endcase
      cc = e ? 3'b000 : {v == 64'd0, $signed(v) < 0, ofl};
   endtask

   task automatic scramble();
      req0_fun = 4'($urandom); req1_fun = 4'($urandom);
      req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
      req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
   endtask

   // One full transaction, entered and left at posedge+1 in IDLE.
   task automatic txn(input logic v0, input logic v1, input logic [3:0] f0, input logic [3:0] f1,
                      input logic [63:0] a0, input logic [63:0] b0,
                      input logic [63:0] a1, input logic [63:0] b1,
                      input int unsigned stall);
      logic g, ee;
      logic [63:0] ev;
      logic [2:0] ecc;
      int unsigned waited;
      req0_valid = v0; req0_fun = f0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_fun = f1; req1_a = a1; req1_b = b1;
      #1;
      waited = 0;
      while (!(req0_ready || req1_ready) && waited < 5) begin
         @(posedge clk); #1; waited++;
      end
      if (!(req0_ready || req1_ready)) begin
         chk("accept_timeout", {63'd0, req0_ready | req1_ready}, 64'd1);
         return;
      end
      // Tie goes to whoever was not served last; otherwise the lone requester.
      g = (v0 && v1) ? !last_m : v1;
      chk("grant_r0", req0_ready, !g);
      chk("grant_r1", req1_ready, g);
      ref_alu(g ? f1 : f0, g ? a1 : a0, g ? b1 : b0, ev, ecc, ee);
      last_m = g;
      @(posedge clk); #1;
      scramble();
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      #1;
      chk("exec_valid", resp_valid, 1'b0);
      chk("exec_ready", {req0_ready, req1_ready}, 2'b00);
      @(posedge clk); #1;
      chk("resp_valid", resp_valid, 1'b1);
      chk("resp_val", resp_val, ev);
      chk("resp_cc", resp_cc, ecc);
      chk("resp_err", resp_err, ee);
      chk("resp_id", resp_id, g);
      for (int unsigned i = 0; i < stall; i++) begin
         req0_valid = 1'b1; req1_valid = 1'b1; scramble();
         #1;
         chk("stall_ready", {req0_ready, req1_ready}, 2'b00);
         @(posedge clk); #1;
         chk("stall_valid", resp_valid, 1'b1);
         chk("stall_val", resp_val, ev);
         chk("stall_cc", {resp_cc, resp_err, resp_id}, {ecc, ee, g});
      end
      req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
      #1;
      chk("done_ready", {req0_ready, req1_ready}, 2'b00);
      @(posedge clk); #1;
      resp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      chk("done_valid", resp_valid, 1'b0);
      chk("held_val", resp_val, ev);
   endtask

   initial begin
      int prev, nacc;
      logic g;
      rst = 1'b1; resp_ready = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_fun = 4'd0; req1_fun = 4'd1;
      req0_a = 64'd1; req0_b = 64'd2; req1_a = 64'd3; req1_b = 64'd4;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
      chk("rst_valid", resp_valid, 1'b0);
      chk("rst_val", resp_val, 64'd0);
      chk("rst_cc", {resp_cc, resp_err, resp_id}, 5'd0);
      rst = 1'b0; last_m = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Directed arithmetic corners.
      txn(1, 0, 4'd0, 4'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 0);
      txn(0, 1, 4'd0, 4'd1, 64'd0, 64'd0, 64'h8000_0000_0000_0000, 64'd1, 1);
      txn(1, 0, 4'd2, 4'd0, 64'd4, 64'd12, 64'd0, 64'd0, 0);
      txn(0, 1, 4'd0, 4'd3, 64'd0, 64'd0, 64'd714278, 64'd714278, 0);
      // Long stall with an invalid function code.
      txn(1, 1, 4'd7, 4'd7, 64'd55, 64'd66, 64'd77, 64'd88, 5);

      // Both valid continuously from reset with resp_ready high.
      rst = 1'b1; resp_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_fun = 4'd0; req1_fun = 4'd1;
      @(posedge clk); #1;
      rst = 1'b0; last_m = 1'b1;
      prev = 0; nacc = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         #1;
         if (req0_ready || req1_ready) begin
            g = !last_m;
            chk("alt_grant", {req0_ready, req1_ready}, {!g, g});
            if (nacc > 0) chk("alt_gap", 64'(cyc - prev), 64'd3);
            prev = cyc; nacc++; last_m = g;
         end
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
      chk("alt_count", 64'(nacc), 64'd4);

      // Reset in EXEC drops the operation.
      req1_valid = 1'b1; req1_fun = 4'd0;
      #1;
      chk("pre_rst_grant", req1_ready, 1'b1);
      @(posedge clk); #1;
      req1_valid = 1'b0; rst = 1'b1; resp_ready = 1'b1;
      @(posedge clk); #1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rst_hold_ready", {req0_ready, req1_ready}, 2'b00);
      @(posedge clk); #1;
      rst = 1'b0; last_m = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("dropped_valid", resp_valid, 1'b0);
         @(posedge clk); #1;
      end
      resp_ready = 1'b0;
      txn(1, 1, 4'd0, 4'd2, 64'd10, 64'd20, 64'd30, 64'd40, 0);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         int unsigned sel;
         logic [63:0] a0, b0, a1, b1;
         sel = $urandom_range(1, 3);
         a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
         a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) a0 = 64'h8000_0000_0000_0000;
         if ($urandom_range(0, 3) == 0) b1 = 64'h7FFF_FFFF_FFFF_FFFF;
         txn(sel[0], sel[1], 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
             a0, b0, a1, b1, $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
